// File: rtl/uart_tx.sv
// UART transmitter with input FIFO and valid/ready handshake; configurable width, stop bits and parity.
// Optional parity bit compiled in when UART_TX_PARITY_EN is defined.
module uart_tx #(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD       = 9600,
   parameter int DATA_BITS  = 8,
   parameter int STOP_BITS  = 1,
   parameter int PARITY_ODD = 0,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_BITS-1:0] data,
   input  logic                 valid,
   output logic                 ready,
   output logic                 tx,
   output logic                 busy
);

   localparam int DIV    = CLK_FREQ / BAUD;
   localparam int CNT_W  = $clog2(DIV);
   localparam int ADDR_W = $clog2(FIFO_DEPTH);
   localparam int PTR_W  = ADDR_W + 1;
   localparam int BIT_W  = $clog2(DATA_BITS);

   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);
   localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;
`else
   typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;
`endif

   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic                 empty, full, push, pop;
   logic [DATA_BITS-1:0] head;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [BIT_W-1:0]     bit_q, bit_d;
   logic                 stop_q, stop_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 tx_q, tx_d;
   logic                 tick;
`ifdef UART_TX_PARITY_EN
   logic                 parity_q, parity_d;
`endif

   // Wrap bit distinguishes full from empty when the low address bits match.
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                  (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
   assign ready = !full;
   assign push  = valid && !full;
   assign head  = mem[rd_ptr_q[ADDR_W-1:0]];
   assign busy  = (state_q != ST_IDLE) || !empty;
   assign tx    = tx_q;

   assign wr_ptr_d = wr_ptr_q + PTR_W'(push);
   assign rd_ptr_d = rd_ptr_q + PTR_W'(pop);

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_q[ADDR_W-1:0]] <= data;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      stop_d  = stop_q;
      shift_d = shift_q;
      pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_d = parity_q;
`endif
      tick = (cnt_q == CNT_LAST);
      if (state_q != ST_IDLE) begin
         cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
      end
      case (state_q)
         ST_IDLE: begin
            if (!empty) pop = 1'b1;
         end
         ST_START: begin
            bit_d = '0;
            if (tick) state_d = ST_DATA;
         end
         ST_DATA: begin
            if (tick) begin
               shift_d = shift_q >> 1;
               if (bit_q == BIT_LAST) begin
                  stop_d = 1'b0;
`ifdef UART_TX_PARITY_EN
                  state_d = ST_PARITY;
`else
                  state_d = ST_STOP;
`endif
               end else begin
                  bit_d = bit_q + BIT_W'(1);
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: begin
            if (tick) state_d = ST_STOP;
         end
`endif
         ST_STOP: begin
            if (tick) begin
               if (stop_q == STOP_LAST) begin
                  // Chain straight into the next start bit when more words are queued.
                  if (!empty) pop = 1'b1;
                  else        state_d = ST_IDLE;
               end else begin
                  stop_d = stop_q + 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (pop) begin
         state_d = ST_START;
         cnt_d   = '0;
         shift_d = head;
`ifdef UART_TX_PARITY_EN
         parity_d = (^head) ^ (PARITY_ODD != 0);
`endif
      end
   end

   always_comb begin
      tx_d = 1'b1;
      case (state_q)
         ST_START:  tx_d = 1'b0;
         ST_DATA:   tx_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
         ST_PARITY: tx_d = parity_q;
`endif
         default:   tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         bit_q    <= '0;
         stop_q   <= 1'b0;
         shift_q  <= '0;
         tx_q     <= 1'b1;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
`ifdef UART_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         bit_q    <= bit_d;
         stop_q   <= stop_d;
         shift_q  <= shift_d;
         tx_q     <= tx_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
`ifdef UART_TX_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

endmodule
